// File: rtl/uabc_test2024.sv
// UABC 2024 test tile: single-digit seven-segment counter with programmable
// step rate, up/down direction and decimal/hex wrap, mirrored on the uio pins.
module uabc_test2024 #(
    parameter int PRESCALE_SHIFT = 20   // must be >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int P_W = PRESCALE_SHIFT + 4;

    typedef struct packed {
        logic [3:0] rate;
        logic       fast;
        logic       hex;
        logic       down;
        logic       run;
    } ctrl_t;

    ctrl_t          ctrl;
    logic [P_W-1:0] last_count;
    logic [P_W-1:0] presc;
    logic           tick;
    logic [3:0]     digit;
    logic [3:0]     digit_next;
    logic [3:0]     max_digit;
    logic           wrap;
    logic           dp;
    logic [6:0]     seg;
    logic           unused_inputs;

    assign ctrl = ctrl_t'(ui_in);
    assign unused_inputs = &{1'b0, uio_in};

    // N-1 without an adder: ((R+1) << S) - 1 is R in the high bits over S ones.
    assign last_count = ctrl.fast ? {{PRESCALE_SHIFT{1'b0}}, ctrl.rate}
                                  : {ctrl.rate, {PRESCALE_SHIFT{1'b1}}};

    // >= rather than == so a shrinking rate ends the current period at once.
    assign tick = ctrl.run & ena & (presc >= last_count);

    assign max_digit = ctrl.hex ? 4'd15 : 4'd9;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch inferred.
        digit_next = digit;
        wrap       = 1'b0;
        if (ctrl.down) begin
            if (digit == 4'd0) begin
                digit_next = max_digit;
                wrap       = 1'b1;
            end else if (digit > max_digit) begin
                digit_next = max_digit;     // out of range after hex->dec: clamp, no wrap
            end else begin
                digit_next = digit - 4'd1;
            end
        end else begin
            if (digit >= max_digit) begin
                digit_next = 4'd0;
                wrap       = 1'b1;
            end else begin
                digit_next = digit + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            presc <= '0;
            digit <= 4'd0;
            dp    <= 1'b0;
        end else if (ctrl.run && ena) begin
            if (tick) begin
                presc <= '0;
                digit <= digit_next;
                dp    <= dp ^ wrap;
            end else begin
                presc <= presc + P_W'(1);
            end
        end
    end

    always_comb begin
        seg = 7'h00;
        unique case (digit)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
        endcase
    end

    assign uo_out  = {dp, seg};
    assign uio_out = {4'b0000, digit};
    assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_uabc_test2024.sv
// Self-checking bench for uabc_test2024: a table of directed vectors for the
// main counting behaviour plus hand sequences for rate, pause, mode and reset.
module tb_uabc_test2024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    uabc_test2024 #(.PRESCALE_SHIFT(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       ena;
        logic [7:0] ui;
        int         edges;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assert reset for one edge, then release just after an edge.
    task automatic apply_reset(input logic [7:0] ui);
        ui_in = ui;
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input string name, input logic e, input logic [7:0] ui,
                                input int edges, input logic [7:0] uo, input logic [7:0] uio);
        vec_t v;
        v.name = name; v.ena = e; v.ui = ui; v.edges = edges;
        v.exp_uo = uo; v.exp_uio = uio;
        return v;
    endfunction

    initial begin
        // Fast decimal up from reset: 1..9 then wrap to 0 with DP set.
        vecs.push_back(mk("up_1", 1'b1, 8'h09, 1, 8'h06, 8'h01));
        vecs.push_back(mk("up_2", 1'b1, 8'h09, 1, 8'h5B, 8'h02));
        vecs.push_back(mk("up_3", 1'b1, 8'h09, 1, 8'h4F, 8'h03));
        vecs.push_back(mk("up_4", 1'b1, 8'h09, 1, 8'h66, 8'h04));
        vecs.push_back(mk("up_5", 1'b1, 8'h09, 1, 8'h6D, 8'h05));
        vecs.push_back(mk("up_6", 1'b1, 8'h09, 1, 8'h7D, 8'h06));
        vecs.push_back(mk("up_7", 1'b1, 8'h09, 1, 8'h07, 8'h07));
        vecs.push_back(mk("up_8", 1'b1, 8'h09, 1, 8'h7F, 8'h08));
        vecs.push_back(mk("up_9", 1'b1, 8'h09, 1, 8'h6F, 8'h09));
        vecs.push_back(mk("up_wrap", 1'b1, 8'h09, 1, 8'hBF, 8'h00));
        // Hex down: 0 -> F wraps and toggles DP back to 0.
        vecs.push_back(mk("dn_wrap", 1'b1, 8'h0F, 1, 8'h71, 8'h0F));
        vecs.push_back(mk("dn_E", 1'b1, 8'h0F, 1, 8'h79, 8'h0E));
        vecs.push_back(mk("dn_D", 1'b1, 8'h0F, 1, 8'h5E, 8'h0D));
        // ena low freezes everything even with run set.
        vecs.push_back(mk("ena_hold", 1'b0, 8'h0F, 20, 8'h5E, 8'h0D));
        vecs.push_back(mk("ena_resume", 1'b1, 8'h0F, 1, 8'h39, 8'h0C));

        ena    = 1'b1;
        uio_in = 8'hFF;
        ui_in  = 8'hA5;
        rst_n  = 1'b0;
        #3;
        check("rst_uo", uo_out, 8'h3F);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'h0F);
        step(3);
        check("rst_hold_uo", uo_out, 8'h3F);
        check("rst_hold_uio", uio_out, 8'h00);

        apply_reset(8'h09);
        foreach (vecs[i]) begin
            ena   = vecs[i].ena;
            ui_in = vecs[i].ui;
            step(vecs[i].edges);
            check({vecs[i].name, "_uo"}, uo_out, vecs[i].exp_uo);
            check({vecs[i].name, "_uio"}, uio_out, vecs[i].exp_uio);
        end
        check("oe_run", uio_oe, 8'h0F);

        // Hex down from reset: first edge wraps 0 -> F with DP = 1.
        apply_reset(8'h0F);
        step(1);
        check("hexdn_first", uo_out, 8'hF1);
        step(1);
        check("hexdn_second", uo_out, 8'hF9);

        // R = 3: one step every 4 edges; a 10-cycle pause delays it by 10.
        apply_reset(8'h39);
        step(3);
        check("rate_e3", uio_out, 8'h00);
        step(1);
        check("rate_e4", uio_out, 8'h01);
        step(3);
        check("rate_e7", uio_out, 8'h01);
        step(1);
        check("rate_e8", uio_out, 8'h02);
        step(2);
        ui_in = 8'h38;
        step(10);
        check("pause_hold", uio_out, 8'h02);
        ui_in = 8'h39;
        step(1);
        check("pause_resume_p3", uio_out, 8'h02);
        step(1);
        check("pause_resume_tick", uio_out, 8'h03);

        // Rate shrinking below the current count ends the period at once.
        apply_reset(8'hF9);
        step(10);
        check("shrink_before", uio_out, 8'h00);
        ui_in = 8'h29;
        step(1);
        check("shrink_tick", uio_out, 8'h01);

        // Slow mode with PRESCALE_SHIFT = 2, R = 1: period (1+1) << 2 = 8.
        apply_reset(8'h11);
        step(7);
        check("slow_e7", uio_out, 8'h00);
        step(1);
        check("slow_e8", uio_out, 8'h01);

        // Hex up to C, then decimal up: out-of-range digit wraps to 0, DP toggles.
        apply_reset(8'h0D);
        step(12);
        check("mode_reach_C", uo_out, 8'h39);
        ui_in = 8'h09;
        step(1);
        check("mode_up_wrap", uo_out, 8'hBF);
        // Same but decimal down: clamps to 9, DP unchanged.
        apply_reset(8'h0D);
        step(12);
        ui_in = 8'h0B;
        step(1);
        check("mode_dn_clamp_uo", uo_out, 8'h6F);
        check("mode_dn_clamp_uio", uio_out, 8'h09);

        // Reset mid-period clears the prescaler as well as the digit.
        apply_reset(8'h39);
        step(5);
        check("midrst_pre", uio_out, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_async", uio_out, 8'h00);
        step(1);
        rst_n = 1'b1;
        step(3);
        check("midrst_p_cleared", uio_out, 8'h00);
        step(1);
        check("midrst_first_tick", uio_out, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
